// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the write-port arbiter and its users.
// Purely declarative: no logic and no state.
package regfile_pkg;

  localparam int NREGS    = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
// Zero latency, stateless; any=0 when req is empty.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] win,
  output logic          any
);

  int            idx;
  logic [PW-1:0] idx_w;

  always_comb begin
    gnt   = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = 0; i < N; i++) begin
      // Offset from the pointer, folded back into 0..N-1 for non-power-of-two N.
      idx   = (int'(ptr) + i) % N;
      idx_w = idx[PW-1:0];
      if (!any && req[idx_w]) begin
        any        = 1'b1;
        win        = idx_w;
        gnt[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter for the register file's single write port; one-cycle registered wr_en/wr_data.
// Backpressure: stall blocks the grant that cycle only; req_ready is combinational from valid/stall/rr_ptr.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  parameter int GW       = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     stall,
  output logic [NREGS-1:0]         wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic [GW-1:0]            grant_id
);

  logic [GW-1:0]     rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic [GW-1:0]     win;
  logic              any;
  logic              hs;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              addr_ok;

  rr_pick #(.N(NREQ), .PW(GW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .win (win),
    .any (any)
  );

  // Ready is forced low during reset so nothing handshakes into a state that is being cleared.
  assign hs        = any && !stall && reset;
  assign req_ready = hs ? gnt : '0;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Out-of-range indices behave like the hardwired-zero register: accepted, never written.
  assign addr_ok = (win_addr != ADDR_W'(ZERO_REG)) && (int'(win_addr) < NREGS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      wr_en    <= '0;
      wr_data  <= '0;
      grant_id <= '0;
    end else begin
      wr_en <= '0;
      if (hs) begin
        rr_ptr   <= (win == GW'(NREQ - 1)) ? '0 : win + 1'b1;
        wr_data  <= win_data;
        grant_id <= win;
        if (addr_ok) wr_en <= NREGS'(1) << win_addr;
      end
    end
  end

endmodule
